stream_fifo: RTL and testbench
==============================

Name: stream_fifo

Overview:
- Synchronous buffering FIFO built on the team's stream handshake (valid/ready/block plus data).
- Acts as the consumer on its input stream (drives ready and block) and as the producer on its output stream (drives valid, data and block).
- Sits between pipeline stages, for example between fetch and decode, to absorb backpressure and decouple timing.
- Outputs are first-word-fall-through: head data appears on out_data while out_valid is high.

Parameters:
- DATA_WIDTH, 32, width of the data word.
- DEPTH, 8, number of entries; power of two, at least 2.
- ALMOST_FULL, 2, in_block asserts when free entries are at or below this value; range 0 to DEPTH-1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous discard of all stored entries.
- in_valid  input  1  upstream word is valid.
- in_data  input  DATA_WIDTH  upstream word.
- in_ready  output  1  FIFO accepts a word this cycle.
- in_block  output  1  almost-full warning to the upstream stage.
- out_valid  output  1  head word is valid.
- out_data  output  DATA_WIDTH  head word.
- out_ready  input  1  downstream consumes the head word.
- out_block  output  1  high for one cycle after a flush is taken.
- count  output  $clog2(DEPTH)+1  number of stored entries.

Behaviour:
- Clock, reset and polarity: one clock, clk. Reset is asynchronous and active-low on port rst.
- Reset values (rst=0): read/write pointers 0, count 0, out_valid 0, in_ready 0, in_block 0, out_block 0. out_data is don't-care; storage is not cleared.
- in_ready is a register. It rises on the first clk edge after rst deasserts, then equals !full.
- Pointers are $clog2(DEPTH)+1 bits wide, with an MSB wrap bit.
  - empty when the pointers are equal.
  - full when the low bits are equal and the MSBs differ.
  - Pointers wrap modulo 2*DEPTH with no special case.
- Push when in_valid && in_ready at a rising edge. Data is written at wptr and wptr increments.
- Pop when out_valid && out_ready at a rising edge. rptr increments.
- out_valid = !empty. out_data = mem[rptr low bits], read combinationally from the register array.
- Latency: a word pushed at edge N is visible on out_valid/out_data after edge N. Minimum one cycle; no combinational in-to-out path.
- Simultaneous push and pop:
  - Both pointers advance and count is unchanged.
  - Legal at any occupancy between 1 and DEPTH-1.
  - At full, in_ready=0 so only the pop occurs; in_ready rises the next cycle. There is no same-cycle pass-through at full.
  - At empty, out_valid=0 so only the push occurs.
- count = wptr - rptr, registered, never exceeds DEPTH.
- in_block, registered = (DEPTH - next_count) <= ALMOST_FULL. With ALMOST_FULL=0 it asserts only at full.
- flush=1 at an edge:
  - Both pointers reset to 0 and count goes to 0.
  - Any push or pop in that cycle is ignored, and the handshake is not honoured even if in_valid && in_ready.
  - out_block=1 for exactly the following cycle.
  - in_ready stays 1 (unless still in the post-reset cycle).
  - Back-to-back flushes keep out_block high continuously.
- Upstream protocol: upstream must hold in_data stable while in_valid && !in_ready. The FIFO does not check this.
- Downstream protocol: out_valid never drops without a pop or a flush. out_data is stable while out_valid && !out_ready.
- Reset mid-operation: all state returns to reset values immediately, asynchronously; in-flight data is lost.
- Static checks: elaboration error if DEPTH is not a power of two, if DEPTH<2, or if ALMOST_FULL>=DEPTH.

Test Plan:
- Reset release, DEPTH=8: in_ready=0 in the first post-reset cycle, 1 from the second. out_valid=0, count=0.
- Fill: push 0x11..0x88 with out_ready=0.
  - in_block rises when count reaches 6.
  - in_ready=0 at count=8.
  - A ninth word held on in_valid is not accepted until one pop.
- Drain: out_ready=1 after the fill. Outputs appear in order 0x11..0x88, one per cycle. out_valid falls after the 8th pop and count=0.
- Streaming: in_valid=out_ready=1 for 100 cycles with an incrementing counter. Output equals input delayed by 1 cycle, count stays 1, and pointers wrap past 15 with no error.
- Flush with count=5 and a push asserted in the same cycle:
  - count=0 next cycle; the pushed word is discarded.
  - out_block=1 for one cycle.
  - The next push appears alone at the head.
- Async reset asserted mid-stream between edges with count=3: outputs go to reset values without a clock edge. After release the FIFO operates from empty.

Source files
------------

// File: rtl/stream_fifo_if.sv
// Stream handshake bundle around a stream_fifo: input stream, output stream,
// flush control and the occupancy count.
interface stream_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
);
  logic                     flush;
  logic                     in_valid;
  logic [DATA_WIDTH-1:0]    in_data;
  logic                     in_ready;
  logic                     in_block;
  logic                     out_valid;
  logic [DATA_WIDTH-1:0]    out_data;
  logic                     out_ready;
  logic                     out_block;
  logic [$clog2(DEPTH):0]   count;

  // The FIFO itself: consumer on the input stream, producer on the output stream.
  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, in_block, out_valid, out_data, out_block, count
  );

  // The surrounding pipeline stages that feed and drain the FIFO.
  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, in_block, out_valid, out_data, out_block, count
  );
endinterface

// File: rtl/stream_fifo.sv
// First-word-fall-through buffering FIFO on the stream handshake, with an
// almost-full warning, synchronous flush and a one-cycle post-flush marker.
module stream_fifo #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 8,
  parameter int ALMOST_FULL = 2
) (
  input  logic              clk,
  input  logic              rst,
  stream_fifo_if.slave      bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_W = PW'(DEPTH);
  localparam logic [PW-1:0] AF_W    = PW'(ALMOST_FULL);

  generate
    if (DEPTH < 2) begin : g_depth_min
      $error("stream_fifo: DEPTH must be at least 2");
    end
    if ((DEPTH & (DEPTH - 1)) != 0) begin : g_depth_pow2
      $error("stream_fifo: DEPTH must be a power of two");
    end
    if (ALMOST_FULL < 0 || ALMOST_FULL >= DEPTH) begin : g_af_range
      $error("stream_fifo: ALMOST_FULL must be in 0..DEPTH-1");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wptr, rptr, count_q;
  logic [PW-1:0] wptr_n, rptr_n, count_n;
  logic          in_ready_q, in_block_q, out_block_q;
  logic          empty, full_n;
  logic          push, pop;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign empty = (wptr == rptr);

  // A flushing cycle honours neither handshake.
  assign push = bus.in_valid  && in_ready_q && !bus.flush;
  assign pop  = !empty        && bus.out_ready && !bus.flush;

  // NOTE: every variable written in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wptr_n = wptr;
    rptr_n = rptr;
    if (bus.flush) begin
      wptr_n = '0;
      rptr_n = '0;
    end else begin
      if (push) wptr_n = wptr + PW'(1);
      if (pop)  rptr_n = rptr + PW'(1);
    end
  end

  assign count_n = wptr_n - rptr_n;
  assign full_n  = (wptr_n[AW-1:0] == rptr_n[AW-1:0]) && (wptr_n[AW] != rptr_n[AW]);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr        <= '0;
      rptr        <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      in_block_q  <= 1'b0;
      out_block_q <= 1'b0;
    end else begin
      wptr        <= wptr_n;
      rptr        <= rptr_n;
      count_q     <= count_n;
      in_ready_q  <= !full_n;
      in_block_q  <= (DEPTH_W - count_n) <= AF_W;
      out_block_q <= bus.flush;
    end
  end

  // NOTE: the storage array has no reset; contents are only observable once
  // the pointers say a slot is valid, so clearing it would buy nothing.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= bus.in_data;
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.in_block  = in_block_q;
  assign bus.out_valid = !empty;
  assign bus.out_data  = mem[rptr[AW-1:0]];
  assign bus.out_block = out_block_q;
  assign bus.count     = count_q;

  // Downstream guarantees: the head stays put until it is popped or flushed.
  a_count_bound : assert property (@(posedge clk) disable iff (!rst)
    count_q <= DEPTH_W);

  a_head_stable : assert property (@(posedge clk) disable iff (!rst)
    (bus.out_valid && !bus.out_ready && !bus.flush)
      |=> (bus.out_valid && $stable(bus.out_data)));

  a_no_push_when_full : assert property (@(posedge clk) disable iff (!rst)
    (count_q == DEPTH_W) |-> !in_ready_q);

endmodule

// File: tb/tb_stream_fifo.sv
// Self-checking bench for stream_fifo: directed scenarios plus random traffic,
// all compared against a queue-based reference model.
module tb_stream_fifo;

  localparam int DATA_WIDTH  = 32;
  localparam int DEPTH       = 8;
  localparam int ALMOST_FULL = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  stream_fifo_if #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) bus ();

  stream_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ALMOST_FULL(ALMOST_FULL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: stored words in order, plus the registered handshake flags.
  logic [DATA_WIDTH-1:0] q[$];
  logic                  m_ready;
  logic                  m_out_block;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ready     = 1'b0;
    m_out_block = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    logic exp_block;
    exp_block = (m_ready || q.size() != 0) ? ((DEPTH - q.size()) <= ALMOST_FULL) : 1'b0;
    check({tag, ".in_ready"},  64'(bus.in_ready),  64'(m_ready));
    check({tag, ".in_block"},  64'(bus.in_block),  64'(exp_block));
    check({tag, ".out_valid"}, 64'(bus.out_valid), 64'(q.size() != 0));
    check({tag, ".count"},     64'(bus.count),     64'(q.size()));
    check({tag, ".out_block"}, 64'(bus.out_block), 64'(m_out_block));
    if (q.size() != 0) check({tag, ".out_data"}, 64'(bus.out_data), 64'(q[0]));
  endtask

  // Check the pre-edge outputs, take one clock edge, advance the model.
  task automatic step(input string tag);
    logic do_push, do_pop, fl;
    logic [DATA_WIDTH-1:0] d;
    check_outputs(tag);
    fl      = bus.flush;
    d       = bus.in_data;
    do_push = bus.in_valid && m_ready && !fl;
    do_pop  = (q.size() != 0) && bus.out_ready && !fl;
    @(posedge clk);
    #1;
    if (fl) q.delete();
    else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(d);
    end
    m_ready     = (q.size() != DEPTH);
    m_out_block = fl;
  endtask

  task automatic drive(input logic v, input logic [DATA_WIDTH-1:0] d, input logic r, input logic f);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    bus.flush     = f;
  endtask

  initial begin
    drive(1'b0, '0, 1'b0, 1'b0);
    model_reset();

    // Reset values, then release between edges.
    #12;
    check_outputs("reset");
    rst = 1'b1;
    step("post_reset");
    step("idle");

    // Fill 0x11..0x88 with the consumer stalled, then hold a ninth word.
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, DATA_WIDTH'(k * 'h11), 1'b0, 1'b0);
      step("fill");
    end
    check("full.count", 64'(bus.count), 64'(DEPTH));
    check("full.in_ready", 64'(bus.in_ready), 64'(0));
    drive(1'b1, 32'h99, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step("hold9");
    drive(1'b1, 32'h99, 1'b1, 1'b0);
    step("pop_at_full");
    step("ninth_accept");

    // Drain everything in order.
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int k = 0; k < DEPTH + 2; k++) step("drain");
    check("drain.empty", 64'(bus.out_valid), 64'(0));

    // Streaming with an incrementing counter; pointers wrap many times.
    for (int k = 0; k < 100; k++) begin
      drive(1'b1, DATA_WIDTH'(32'h1000 + k), 1'b1, 1'b0);
      step("stream");
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    step("stream_tail");
    step("stream_idle");

    // Flush at count=5 with a push in the same cycle.
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, DATA_WIDTH'(32'hA0 + k), 1'b0, 1'b0);
      step("pre_flush");
    end
    drive(1'b1, 32'hDEAD, 1'b0, 1'b1);
    step("flush");
    check("flush.count", 64'(bus.count), 64'(0));
    check("flush.out_block", 64'(bus.out_block), 64'(1));
    drive(1'b1, 32'hBEEF, 1'b0, 1'b0);
    step("after_flush");
    drive(1'b0, '0, 1'b0, 1'b0);
    step("head_after_flush");
    check("flush.head", 64'(bus.out_data), 64'(32'hBEEF));

    // Back-to-back flushes keep out_block high.
    drive(1'b0, '0, 1'b0, 1'b1);
    step("flush2a");
    step("flush2b");
    drive(1'b0, '0, 1'b0, 1'b0);
    step("flush2_end");
    step("flush2_idle");

    // Asynchronous reset between edges with three words in flight.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, DATA_WIDTH'(32'hC0 + k), 1'b0, 1'b0);
      step("pre_areset");
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, DATA_WIDTH'(32'hD0 + k), 1'b1, 1'b0);
      step("midstream");
    end
    check("areset.pre_count", 64'(bus.count), 64'(3));
    #3 rst = 1'b0;
    #1;
    model_reset();
    check_outputs("areset");
    drive(1'b0, '0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    step("areset_release");
    drive(1'b1, 32'h5A5A, 1'b0, 1'b0);
    step("areset_push");
    drive(1'b0, '0, 1'b1, 1'b0);
    step("areset_pop");
    step("areset_idle");

    // Random traffic with phases biased toward full and toward empty.
    for (int k = 0; k < 2000; k++) begin
      int bias;
      bias = (k / 200) % 3;
      if (!(bus.in_valid && !bus.in_ready)) begin
        bus.in_valid = ($urandom_range(0, 9) < (bias == 0 ? 8 : (bias == 1 ? 2 : 5)));
        bus.in_data  = $urandom;
      end
      bus.out_ready = ($urandom_range(0, 9) < (bias == 0 ? 2 : (bias == 1 ? 8 : 5)));
      bus.flush     = ($urandom_range(0, 63) == 0);
      step("random");
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    step("final");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
